tlp_rx_hdr_parser: RTL and testbench
====================================

TLP_RX_HDR_PARSER -- requirements
Module: tlp_rx_hdr_parser

Interface
REQ-001 SHALL have parameter SUPPORT_10BIT_TAG, default 0: 0 means 8-bit tags only, 1 means 10-bit tags accepted.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream DW valid.
- in_ready  out  1  parser accepts DW.
- in_data  in  32  TLP DW, header first, big-endian field order.
- in_sop  in  1  first DW of TLP.
- in_eop  in  1  last DW of TLP.
- ari_enabled  in  1  requester ID interpreted as bus[15:8] and fnc[7:0].
- hdr_valid  out  1  parsed header available.
- hdr_ready  in  1  downstream accepts header.
- hdr_fmt  out  3  DW0[31:29].
- hdr_type  out  5  DW0[28:24].
- hdr_tc  out  3  DW0[22:20].
- hdr_attr  out  3  {DW0[18], DW0[13:12]}.
- hdr_td  out  1  DW0[15].
- hdr_ep  out  1  DW0[14].
- hdr_length  out  10  DW0[9:0].
- hdr_bus  out  8  DW1[31:24].
- hdr_dev  out  5  DW1[23:19] when ARI is off; 0 when ARI is on.
- hdr_fnc  out  8  {5'b0, DW1[18:16]} when ARI is off; DW1[23:16] when ARI is on.
- hdr_tag  out  10  {DW0[23] T9, DW0[19] T8, DW1[15:8]}.
- hdr_first_be  out  4  DW1[3:0].
- hdr_last_be  out  4  DW1[7:4].
- hdr_addr  out  64  address, bits [1:0] forced to 0.
- hdr_err  out  3  error flags (REQ-012).

Function
REQ-003 SHALL implement FSM states IDLE, DW1, DW2, DW3, PAYLOAD, DONE.
REQ-004 A DW SHALL be accepted only when in_valid and in_ready are both 1.
REQ-005 in_ready SHALL equal !hdr_valid, so the parser stalls while its single output slot is full.
REQ-006 IDLE transitions:
- Accepted DW with in_sop=1 SHALL capture DW0 and go to DW1.
- Accepted DW with in_sop=0 SHALL be discarded; state stays IDLE.
REQ-007 Header DWs:
- DW1 SHALL capture the requester ID, tag[7:0] and byte enables.
- DW2 SHALL capture addr[31:2] when fmt[0]=0 (3DW header), else addr[63:32].
- DW3 (4DW only) SHALL capture addr[31:2].
- For 3DW headers, addr[63:32] SHALL be 0.
REQ-008 After the last header DW, the FSM SHALL go to PAYLOAD if fmt[1]=1 (with data); otherwise the header DW SHALL carry in_eop, and the FSM goes to DONE.
REQ-009 PAYLOAD SHALL count accepted DWs in an 11-bit counter saturating at 2047, and SHALL go to DONE on the accepted DW with in_eop=1.
REQ-010 DONE SHALL assert hdr_valid on the cycle after the eop DW is accepted (latency 1 cycle), and SHALL return to IDLE the same cycle.
- hdr_valid SHALL stay 1, with all hdr_* outputs stable, until a cycle with hdr_ready=1.
REQ-011 An accepted in_sop=1 in any state other than IDLE SHALL discard the partial TLP, with no hdr_valid for it, and restart at DW1 capturing the new DW0.
REQ-012 hdr_err bits SHALL be computed at eop:
- [0] tag error: SUPPORT_10BIT_TAG=0 and {T9,T8} != 2'b00.
- [1] length error: in_eop before the header is complete; or fmt[1]=1 and payload count != expected length (length 0 means 1024); or fmt[1]=0 and a DW arrives after the header without eop.
- [2] format error: fmt=3'b100 (TLP prefix) or fmt[2]=1.
REQ-013 On a header early eop, the FSM SHALL go directly to DONE; uncaptured fields SHALL be 0.
REQ-014 When SUPPORT_10BIT_TAG=0, hdr_tag[9:8] SHALL be output as 2'b00 regardless of T9/T8.
REQ-015 ari_enabled SHALL be sampled when DW1 is accepted.

Reset
REQ-016 When rst=1 at a clock edge:
- FSM SHALL go to IDLE.
- hdr_valid, hdr_err and all hdr_* fields SHALL be 0; the payload counter SHALL be 0.
- in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-017 Reset mid-packet SHALL discard the partial TLP; no hdr_valid results from it.

Verification
REQ-018 3DW MemRd, DW0=0x00000001, DW1=0x0100_2A0F, DW2=0x0000_1004 with eop, hdr_ready=1 -> one cycle later hdr_valid=1, hdr_length=1, hdr_bus=0x01, hdr_dev=0, hdr_fnc=0, hdr_tag=0x02A, hdr_first_be=0xF, hdr_addr=0x1004, hdr_err=0.
REQ-019 4DW MemWr, DW0=0x60000002, addr 0x1_0000_0008, two payload DWs, eop on the second -> hdr_addr=0x0000_0001_0000_0008, hdr_err=0; the same packet with three payload DWs -> hdr_err=3'b010.
REQ-020 SUPPORT_10BIT_TAG=0, DW0 bit 23=1 -> hdr_err[0]=1, hdr_tag[9:8]=00; with SUPPORT_10BIT_TAG=1 -> hdr_err=0, hdr_tag[9]=1.
REQ-021 ARI on, DW1[31:16]=0x05A3 -> hdr_bus=0x05, hdr_fnc=0xA3, hdr_dev=0; ARI off -> hdr_dev=0x14, hdr_fnc=0x03.
REQ-022 Hold hdr_ready=0 for 5 cycles with a second TLP pending -> in_ready=0 and outputs stable; hdr_ready=1 -> next TLP parsed correctly.
REQ-023 sop asserted at DW2 of a TLP, then rst asserted mid-payload -> no hdr_valid for either TLP; in_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/tlp_rx_hdr_parser.sv
// PCIe TLP receive header parser: walks a DW stream, extracts the 3DW/4DW header fields
// and flags tag, length and format errors; one header is held until downstream takes it.
module tlp_rx_hdr_parser #(
    parameter bit SUPPORT_10BIT_TAG = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic        ari_enabled,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [2:0]  hdr_fmt,
    output logic [4:0]  hdr_type,
    output logic [2:0]  hdr_tc,
    output logic [2:0]  hdr_attr,
    output logic        hdr_td,
    output logic        hdr_ep,
    output logic [9:0]  hdr_length,
    output logic [7:0]  hdr_bus,
    output logic [4:0]  hdr_dev,
    output logic [7:0]  hdr_fnc,
    output logic [9:0]  hdr_tag,
    output logic [3:0]  hdr_first_be,
    output logic [3:0]  hdr_last_be,
    output logic [63:0] hdr_addr,
    output logic [2:0]  hdr_err
);

    localparam int unsigned CNT_W = 11;

    typedef enum logic [2:0] {IDLE, DW1, DW2, DW3, PAYLOAD, DONE} state_t;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  typ;
        logic [2:0]  tc;
        logic [2:0]  attr;
        logic        td;
        logic        ep;
        logic [9:0]  length;
        logic [7:0]  bus;
        logic [4:0]  dev;
        logic [7:0]  fnc;
        logic [9:0]  tag;
        logic [3:0]  first_be;
        logic [3:0]  last_be;
        logic [63:0] addr;
    } hdr_t;

    state_t           state;
    hdr_t             work;
    hdr_t             nxt;
    hdr_t             out;
    logic [CNT_W-1:0] pay_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] exp_len;
    logic             acc;
    logic             len_err;
    logic             tag_err;
    logic             fmt_err;

    assign in_ready = ~hdr_valid;
    assign acc      = in_valid & in_ready;

    // Header fields as they will look once the current DW is absorbed.
    always_comb begin
        nxt = work;
        if (in_sop) begin
            nxt        = '0;
            nxt.fmt    = in_data[31:29];
            nxt.typ    = in_data[28:24];
            nxt.tc     = in_data[22:20];
            nxt.attr   = {in_data[18], in_data[13:12]};
            nxt.td     = in_data[15];
            nxt.ep     = in_data[14];
            nxt.length = in_data[9:0];
            nxt.tag    = {in_data[23], in_data[19], 8'h00};
        end else begin
            case (state)
                DW1: begin
                    nxt.bus      = in_data[31:24];
                    nxt.dev      = ari_enabled ? 5'd0 : in_data[23:19];
                    nxt.fnc      = ari_enabled ? in_data[23:16] : {5'd0, in_data[18:16]};
                    nxt.tag[7:0] = in_data[15:8];
                    nxt.last_be  = in_data[7:4];
                    nxt.first_be = in_data[3:0];
                end
                DW2: begin
                    if (work.fmt[0]) nxt.addr[63:32] = in_data;
                    else             nxt.addr[31:0]  = {in_data[31:2], 2'b00};
                end
                DW3:     nxt.addr[31:0] = {in_data[31:2], 2'b00};
                default: nxt = work;
            endcase
        end
    end

    // Error terms evaluated against the DW carrying eop.
    always_comb begin
        cnt_inc = (pay_cnt == '1) ? pay_cnt : pay_cnt + CNT_W'(1);
        exp_len = (work.length == '0) ? CNT_W'(1024) : CNT_W'(work.length);
        tag_err = !SUPPORT_10BIT_TAG && (nxt.tag[9:8] != 2'b00);
        fmt_err = (nxt.fmt == 3'b100) || nxt.fmt[2];
        len_err = 1'b1;
        if (!in_sop) begin
            case (state)
                DW2:     len_err = work.fmt[0] | work.fmt[1];
                DW3:     len_err = work.fmt[1];
                PAYLOAD: len_err = work.fmt[1] ? (cnt_inc != exp_len) : 1'b1;
                default: len_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            out       <= '0;
            pay_cnt   <= '0;
            hdr_valid <= 1'b0;
            hdr_err   <= '0;
        end else begin
            if (hdr_valid && hdr_ready) hdr_valid <= 1'b0;
            if (state == DONE) begin
                state <= IDLE;
            end else if (acc && (in_sop || state != IDLE)) begin
                work    <= nxt;
                pay_cnt <= in_sop ? '0 : ((state == PAYLOAD) ? cnt_inc : pay_cnt);
                if (in_eop) begin
                    out       <= nxt;
                    hdr_err   <= {fmt_err, len_err, tag_err};
                    hdr_valid <= 1'b1;
                    state     <= DONE;
                end else if (in_sop) begin
                    state <= DW1;
                end else begin
                    case (state)
                        DW1:     state <= DW2;
                        DW2:     state <= work.fmt[0] ? DW3 : PAYLOAD;
                        DW3:     state <= PAYLOAD;
                        default: state <= state;
                    endcase
                end
            end
        end
    end

    assign hdr_fmt      = out.fmt;
    assign hdr_type     = out.typ;
    assign hdr_tc       = out.tc;
    assign hdr_attr     = out.attr;
    assign hdr_td       = out.td;
    assign hdr_ep       = out.ep;
    assign hdr_length   = out.length;
    assign hdr_bus      = out.bus;
    assign hdr_dev      = out.dev;
    assign hdr_fnc      = out.fnc;
    assign hdr_tag      = SUPPORT_10BIT_TAG ? out.tag : {2'b00, out.tag[7:0]};
    assign hdr_first_be = out.first_be;
    assign hdr_last_be  = out.last_be;
    assign hdr_addr     = out.addr;

endmodule

// File: tb/tb_tlp_rx_hdr_parser.sv
// Scoreboard bench: two parsers (8-bit and 10-bit tag builds) share one stimulus stream;
// a whole-packet reference model predicts each header.
module tb_tlp_rx_hdr_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic        ari_enabled = 1'b0;
    logic        hdr_ready = 1'b1;

    logic        in_ready0, in_ready1, hdr_valid0, hdr_valid1, td0, td1, ep0, ep1;
    logic [2:0]  fmt0, fmt1, tc0, tc1, attr0, attr1, err0, err1;
    logic [4:0]  typ0, typ1, dev0, dev1;
    logic [9:0]  len0, len1, tag0, tag1;
    logic [7:0]  bus0, bus1, fnc0, fnc1;
    logic [3:0]  fbe0, fbe1, lbe0, lbe1;
    logic [63:0] addr0, addr1;
    logic [131:0] obs0, obs1;

    typedef struct {
        logic [131:0] v0;
        logic [131:0] v1;
    } exp_t;

    exp_t  sb[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    n_fail = 0;
    int    n_hdr = 0;
    int    n_push = 0;
    string cur = "reset";

    always #5 clk = ~clk;

    assign obs0 = {fmt0, typ0, tc0, attr0, td0, ep0, len0, bus0, dev0, fnc0, tag0, fbe0, lbe0, addr0, err0};
    assign obs1 = {fmt1, typ1, tc1, attr1, td1, ep1, len1, bus1, dev1, fnc1, tag1, fbe1, lbe1, addr1, err1};

    tlp_rx_hdr_parser #(.SUPPORT_10BIT_TAG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .ari_enabled(ari_enabled), .hdr_valid(hdr_valid0),
        .hdr_ready(hdr_ready), .hdr_fmt(fmt0), .hdr_type(typ0), .hdr_tc(tc0), .hdr_attr(attr0),
        .hdr_td(td0), .hdr_ep(ep0), .hdr_length(len0), .hdr_bus(bus0), .hdr_dev(dev0),
        .hdr_fnc(fnc0), .hdr_tag(tag0), .hdr_first_be(fbe0), .hdr_last_be(lbe0),
        .hdr_addr(addr0), .hdr_err(err0)
    );

    tlp_rx_hdr_parser #(.SUPPORT_10BIT_TAG(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .ari_enabled(ari_enabled), .hdr_valid(hdr_valid1),
        .hdr_ready(hdr_ready), .hdr_fmt(fmt1), .hdr_type(typ1), .hdr_tc(tc1), .hdr_attr(attr1),
        .hdr_td(td1), .hdr_ep(ep1), .hdr_length(len1), .hdr_bus(bus1), .hdr_dev(dev1),
        .hdr_fnc(fnc1), .hdr_tag(tag1), .hdr_first_be(fbe1), .hdr_last_be(lbe1),
        .hdr_addr(addr1), .hdr_err(err1)
    );

    task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s [%s]: observed 0x%0h expected 0x%0h", tag, cur, obs, exp);
        end
    endtask

    // Reference: decode a complete packet as seen from sop to eop.
    function automatic exp_t model(input logic [31:0] p[$], input bit ari);
        logic [31:0] d0, d1, d2, d3;
        logic [2:0]  fmt;
        logic [4:0]  dev;
        logic [7:0]  fnc;
        logic [63:0] addr;
        logic        lerr, ferr;
        int          n, hdr_n, pay, explen;
        exp_t        e;
        n    = p.size();
        d0   = p[0];
        d1   = (n > 1) ? p[1] : 32'd0;
        d2   = (n > 2) ? p[2] : 32'd0;
        d3   = (n > 3) ? p[3] : 32'd0;
        fmt  = d0[31:29];
        hdr_n = fmt[0] ? 4 : 3;
        dev  = ari ? 5'd0 : d1[23:19];
        fnc  = ari ? d1[23:16] : {5'd0, d1[18:16]};
        if (n <= 1) begin
            dev = 5'd0;
            fnc = 8'd0;
        end
        addr = '0;
        if (fmt[0]) begin
            addr[63:32] = d2;
            addr[31:0]  = {d3[31:2], 2'b00};
        end else begin
            addr[31:0]  = {d2[31:2], 2'b00};
        end
        explen = (d0[9:0] == 10'd0) ? 1024 : int'(d0[9:0]);
        pay    = n - hdr_n;
        lerr   = (n < hdr_n) || (fmt[1] ? (pay != explen) : (pay != 0));
        ferr   = fmt[2];
        e.v0 = {fmt, d0[28:24], d0[22:20], d0[18], d0[13:12], d0[15], d0[14], d0[9:0],
                d1[31:24], dev, fnc, 2'b00, d1[15:8], d1[3:0], d1[7:4], addr,
                ferr, lerr, d0[23] | d0[19]};
        e.v1 = {fmt, d0[28:24], d0[22:20], d0[18], d0[13:12], d0[15], d0[14], d0[9:0],
                d1[31:24], dev, fnc, d0[23], d0[19], d1[15:8], d1[3:0], d1[7:4], addr,
                ferr, lerr, 1'b0};
        return e;
    endfunction

    task automatic send_dw(input logic [31:0] d, input logic sop, input logic eop);
        int k = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        while (!in_ready0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("in_ready_timeout", 132'(in_ready0), 132'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] p[$], input bit ari, input bit push, input bit eop_last);
        ari_enabled = ari;
        if (push) begin
            sb.push_back(model(p, ari));
            n_push++;
        end
        for (int i = 0; i < p.size(); i++)
            send_dw(p[i], i == 0, eop_last && (i == p.size() - 1));
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 132'(sb.size()), 132'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Header consumed when valid meets ready; compare both builds against the model.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && hdr_valid0 && hdr_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_hdr", 132'(hdr_valid0), 132'd0);
            end else begin
                e = sb.pop_front();
                chk("hdr_tag8", obs0, e.v0);
                chk("hdr_tag10", obs1, e.v1);
                chk("valid_tag10", 132'(hdr_valid1), 132'd1);
                n_hdr++;
            end
        end
    end

    initial begin
        logic [31:0] pkt[$];
        logic [31:0] p2[$];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 132'({in_ready0, in_ready1}), 132'd3);
        chk("rst_valid", 132'({hdr_valid0, hdr_valid1}), 132'd0);
        chk("rst_fields0", obs0, 132'd0);
        chk("rst_fields1", obs1, 132'd0);

        cur = "memrd3";
        pkt = '{32'h0000_0001, 32'h0100_2A0F, 32'h0000_1004};
        send_pkt(pkt, 1'b0, 1'b1, 1'b1);
        chk("latency_valid", 132'(hdr_valid0), 132'd1);

        cur = "memwr4_ok";
        pkt = '{32'h6000_0002, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0008, 32'hAAAA_0001, 32'hBBBB_0002};
        send_pkt(pkt, 1'b0, 1'b1, 1'b1);
        cur = "memwr4_long";
        pkt.push_back(32'hCCCC_0003);
        send_pkt(pkt, 1'b0, 1'b1, 1'b1);

        cur = "tag_t9";
        pkt = '{32'h0080_0001, 32'h0200_1103, 32'h0000_2000};
        send_pkt(pkt, 1'b0, 1'b1, 1'b1);
        cur = "tag_t8_4dw";
        pkt = '{32'h6008_0001, 32'h0300_44F0, 32'h0000_0002, 32'h0000_0040, 32'h1234_5678};
        send_pkt(pkt, 1'b0, 1'b1, 1'b1);

        cur = "ari_on";
        pkt = '{32'h0000_0001, 32'h05A3_100F, 32'h0000_3008};
        send_pkt(pkt, 1'b1, 1'b1, 1'b1);
        cur = "ari_off";
        send_pkt(pkt, 1'b0, 1'b1, 1'b1);

        cur = "fmt_prefix";
        pkt = '{32'h8000_0001, 32'h0100_0001, 32'h0000_0010};
        send_pkt(pkt, 1'b0, 1'b1, 1'b1);
        cur = "early_eop";
        pkt = '{32'h6000_0002, 32'h0100_0001};
        send_pkt(pkt, 1'b0, 1'b1, 1'b1);
        cur = "nodata_extra";
        pkt = '{32'h0000_0001, 32'h0100_0001, 32'h0000_0020, 32'h0000_0000};
        send_pkt(pkt, 1'b0, 1'b1, 1'b1);
        cur = "memwr3_attrs";
        pkt = '{32'h4074_F001, 32'h0100_0001, 32'h0000_0030, 32'hFEED_0001};
        send_pkt(pkt, 1'b0, 1'b1, 1'b1);

        cur = "restart";
        pkt = '{32'h6000_0002, 32'h0100_0001};
        send_pkt(pkt, 1'b0, 1'b0, 1'b0);
        pkt = '{32'h0000_0001, 32'h0700_0501, 32'h0000_4444};
        send_pkt(pkt, 1'b0, 1'b1, 1'b1);

        cur = "idle_discard";
        send_dw(32'hDEAD_BEEF, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        wait_drain();

        cur = "stall";
        @(posedge clk);
        #1 hdr_ready = 1'b0;
        pkt = '{32'h0000_0001, 32'h0400_0101, 32'h0000_5000};
        send_pkt(pkt, 1'b0, 1'b1, 1'b1);
        p2 = '{32'h4000_0002, 32'h0500_0201, 32'h0000_6000, 32'h0000_0001, 32'h0000_0002};
        fork
            send_pkt(p2, 1'b0, 1'b1, 1'b1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_valid", 132'(hdr_valid0), 132'd1);
                    chk("stall_in_ready", 132'({in_ready0, in_ready1}), 132'd0);
                    chk("stall_hold", obs0, sb[0].v0);
                end
                @(posedge clk);
                #1 hdr_ready = 1'b1;
            end
        join
        wait_drain();

        cur = "sop_then_reset";
        pkt = '{32'h6000_0002, 32'h0100_0001};
        send_pkt(pkt, 1'b0, 1'b0, 1'b0);
        pkt = '{32'h4000_0004, 32'h0100_0001, 32'h0000_7000, 32'h0000_0001, 32'h0000_0002};
        send_pkt(pkt, 1'b0, 1'b0, 1'b0);
        do_reset();
        @(negedge clk);
        chk("post_rst_in_ready", 132'(in_ready0), 132'd1);
        chk("post_rst_valid", 132'({hdr_valid0, hdr_valid1}), 132'd0);
        repeat (10) @(negedge clk);

        cur = "after_reset";
        pkt = '{32'h0000_0001, 32'h0800_0901, 32'h0000_8004};
        send_pkt(pkt, 1'b0, 1'b1, 1'b1);
        wait_drain();
        chk("hdr_count", 132'(n_hdr), 132'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
